// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_pkg
// Purpose  : Instruction codes, memory-function decoder and shared widths
//            for the MEM pipeline stage.
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int WIDTH_INSTR = 6;
    localparam int WIDTH_T     = 2;

    typedef enum logic [WIDTH_INSTR-1:0] {
        IC_NOP  = 6'd0,
        IC_ADDU = 6'd1,
        IC_SUBU = 6'd2,
        IC_ORI  = 6'd3,
        IC_LUI  = 6'd4,
        IC_LW   = 6'd5,
        IC_LH   = 6'd6,
        IC_LHU  = 6'd7,
        IC_LB   = 6'd8,
        IC_LBU  = 6'd9,
        IC_SW   = 6'd10,
        IC_SH   = 6'd11,
        IC_SB   = 6'd12,
        IC_BEQ  = 6'd13,
        IC_JAL  = 6'd14
    } instr_e;

    typedef enum logic [1:0] {
        FUNC_NONE      = 2'd0,
        FUNC_MEM_READ  = 2'd1,
        FUNC_MEM_WRITE = 2'd2
    } func_e;

    function automatic func_e ic_decode(input logic [WIDTH_INSTR-1:0] ic);
        case (ic)
            IC_LW, IC_LH, IC_LHU, IC_LB, IC_LBU: ic_decode = FUNC_MEM_READ;
            IC_SW, IC_SH, IC_SB:                 ic_decode = FUNC_MEM_WRITE;
            default:                             ic_decode = FUNC_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_align
// Purpose  : Sub-word store lane formatting, load extraction/extension and
//            alignment checking for the MEM stage.
// Revision : 1.0 - initial release
// ============================================================================
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]             i_addr_lo,
    input  logic [WIDTH_INSTR-1:0] i_instr,
    input  logic [31:0]            i_rt,
    input  logic [31:0]            i_rdata,
    output logic [3:0]             o_be,
    output logic [31:0]            o_wdata,
    output logic [31:0]            o_load_data,
    output logic                   o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_be        = 4'b0000;
        o_wdata     = '0;
        o_load_data = '0;
        o_misalign  = 1'b0;
        case (i_instr)
            IC_SW: begin
                o_be       = 4'b1111;
                o_wdata    = i_rt;
                o_misalign = |i_addr_lo;
            end
            IC_SH: begin
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_rt[15:0]}};
                o_misalign = i_addr_lo[0];
            end
            IC_SB: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_rt[7:0]}};
            end
            IC_LW: begin
                o_load_data = i_rdata;
                o_misalign  = |i_addr_lo;
            end
            IC_LH: begin
                o_load_data = {{16{w_half[15]}}, w_half};
                o_misalign  = i_addr_lo[0];
            end
            IC_LHU: begin
                o_load_data = {16'h0000, w_half};
                o_misalign  = i_addr_lo[0];
            end
            IC_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
            IC_LBU:  o_load_data = {24'h000000, w_byte};
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Pipeline MEM stage: req/ack data-memory access FSM, store-data
//            forwarding, access-error detection and the MEM/WB register.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] DM_BASE = 32'h0000_0000,
    parameter logic [31:0] DM_SIZE = 32'h0000_3000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic [WIDTH_INSTR-1:0] instr_mem,
    input  logic [31:0]            pc_mem,
    input  logic [31:0]            alu_out_mem,
    input  logic [31:0]            mem_wdata_mem,
    input  logic [4:0]             addr_rt_mem,
    input  logic [4:0]             reg_waddr_mem,
    input  logic [31:0]            reg_wdata_mem,
    input  logic [WIDTH_T-1:0]     tnew_mem,
    input  logic [4:0]             regaddr_wb,
    input  logic [31:0]            regdata_wb,
    output logic                   dm_req,
    output logic                   dm_we,
    output logic [31:0]            dm_addr,
    output logic [3:0]             dm_be,
    output logic [31:0]            dm_wdata,
    input  logic [31:0]            dm_rdata,
    input  logic                   dm_ack,
    output logic                   mem_busy,
    output logic [WIDTH_INSTR-1:0] instr_wb,
    output logic [31:0]            pc_wb,
    output logic [4:0]             reg_waddr_wb,
    output logic [31:0]            reg_wdata_wb,
    output logic [WIDTH_T-1:0]     tnew_wb,
    output logic                   acc_err_wb
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e r_state;
    state_e w_state_nxt;

    func_e        w_func;
    logic         w_is_load;
    logic         w_is_store;
    logic         w_is_mem;
    logic [31:0]  w_rt;
    logic [31:0]  w_offset;
    logic         w_oob;
    logic         w_misalign;
    logic         w_err;
    logic         w_start;
    logic         w_busy;
    logic [3:0]   w_be;
    logic [31:0]  w_wdata;
    logic [31:0]  w_load_data;
    logic [WIDTH_T-1:0] w_tnew_dec;

    logic         r_dm_req;
    logic         r_dm_we;
    logic [31:0]  r_dm_addr;
    logic [3:0]   r_dm_be;
    logic [31:0]  r_dm_wdata;
    logic [31:0]  r_rdata;

    logic [WIDTH_INSTR-1:0] r_instr_wb;
    logic [31:0]            r_pc_wb;
    logic [4:0]             r_reg_waddr_wb;
    logic [31:0]            r_reg_wdata_wb;
    logic [WIDTH_T-1:0]     r_tnew_wb;
    logic                   r_acc_err_wb;

    assign w_func     = ic_decode(instr_mem);
    assign w_is_load  = (w_func == FUNC_MEM_READ);
    assign w_is_store = (w_func == FUNC_MEM_WRITE);
    assign w_is_mem   = w_is_load | w_is_store;

    // $0 is never a real producer, so a WB write to it must not forward.
    assign w_rt = ((regaddr_wb == addr_rt_mem) && (regaddr_wb != 5'd0)) ? regdata_wb : mem_wdata_mem;

    // Offset subtraction wraps addresses below DM_BASE to huge values, so
    // one unsigned compare covers both ends of the window.
    assign w_offset = alu_out_mem - DM_BASE;
    assign w_oob    = (w_offset >= DM_SIZE);
    assign w_err    = w_is_mem & (w_misalign | w_oob);

    assign w_start  = (r_state == ST_IDLE) & w_is_mem & ~w_err;
    assign w_busy   = w_start | (r_state == ST_WAIT);
    assign mem_busy = w_busy;

    assign w_tnew_dec = (tnew_mem != '0) ? tnew_mem - WIDTH_T'(1) : '0;

    // Load extraction runs off the data captured at ack time, so DONE sees
    // a stable value while the instruction is still held in EX/MEM.
    mem_align u_align (
        .i_addr_lo   (alu_out_mem[1:0]),
        .i_instr     (instr_mem),
        .i_rt        (w_rt),
        .i_rdata     (r_rdata),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_load_data (w_load_data),
        .o_misalign  (w_misalign)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = ST_WAIT;
            ST_WAIT: if (dm_ack)  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dm_req   <= 1'b0;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_be    <= 4'b0000;
            r_dm_wdata <= '0;
            r_rdata    <= '0;
        end else if (w_start) begin
            r_dm_req   <= 1'b1;
            r_dm_we    <= w_is_store;
            r_dm_addr  <= {alu_out_mem[31:2], 2'b00};
            r_dm_be    <= w_be;
            r_dm_wdata <= w_wdata;
        end else if ((r_state == ST_WAIT) && dm_ack) begin
            r_dm_req   <= 1'b0;
            r_rdata    <= dm_rdata;
        end
    end

    assign dm_req   = r_dm_req;
    assign dm_we    = r_dm_we;
    assign dm_addr  = r_dm_addr;
    assign dm_be    = r_dm_be;
    assign dm_wdata = r_dm_wdata;

    // A busy cycle loads a bubble so WB never sees the same instruction twice.
    always_ff @(posedge clk) begin
        if (reset || clr || w_busy) begin
            r_instr_wb     <= '0;
            r_pc_wb        <= '0;
            r_reg_waddr_wb <= '0;
            r_reg_wdata_wb <= '0;
            r_tnew_wb      <= '0;
            r_acc_err_wb   <= 1'b0;
        end else begin
            r_instr_wb     <= instr_mem;
            r_pc_wb        <= pc_mem;
            r_reg_waddr_wb <= w_err ? 5'd0 : reg_waddr_mem;
            r_reg_wdata_wb <= (w_is_load && !w_err) ? w_load_data : reg_wdata_mem;
            r_tnew_wb      <= w_tnew_dec;
            r_acc_err_wb   <= w_err;
        end
    end

    assign instr_wb     = r_instr_wb;
    assign pc_wb        = r_pc_wb;
    assign reg_waddr_wb = r_reg_waddr_wb;
    assign reg_wdata_wb = r_reg_wdata_wb;
    assign tnew_wb      = r_tnew_wb;
    assign acc_err_wb   = r_acc_err_wb;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Directed and randomised MEM-stage transactions scored against a
//            behavioural model of the access rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
    import mem_stage_pkg::*;

    // The design's data window starts at 0, so only the upper bound can be hit.
    localparam logic [31:0] DM_TOP = 32'h0000_3000;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   clr;
    logic [WIDTH_INSTR-1:0] instr_mem;
    logic [31:0]            pc_mem;
    logic [31:0]            alu_out_mem;
    logic [31:0]            mem_wdata_mem;
    logic [4:0]             addr_rt_mem;
    logic [4:0]             reg_waddr_mem;
    logic [31:0]            reg_wdata_mem;
    logic [WIDTH_T-1:0]     tnew_mem;
    logic [4:0]             regaddr_wb;
    logic [31:0]            regdata_wb;
    logic                   dm_req;
    logic                   dm_we;
    logic [31:0]            dm_addr;
    logic [3:0]             dm_be;
    logic [31:0]            dm_wdata;
    logic [31:0]            dm_rdata;
    logic                   dm_ack;
    logic                   mem_busy;
    logic [WIDTH_INSTR-1:0] instr_wb;
    logic [31:0]            pc_wb;
    logic [4:0]             reg_waddr_wb;
    logic [31:0]            reg_wdata_wb;
    logic [WIDTH_T-1:0]     tnew_wb;
    logic                   acc_err_wb;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk           (clk),
        .reset         (reset),
        .clr           (clr),
        .instr_mem     (instr_mem),
        .pc_mem        (pc_mem),
        .alu_out_mem   (alu_out_mem),
        .mem_wdata_mem (mem_wdata_mem),
        .addr_rt_mem   (addr_rt_mem),
        .reg_waddr_mem (reg_waddr_mem),
        .reg_wdata_mem (reg_wdata_mem),
        .tnew_mem      (tnew_mem),
        .regaddr_wb    (regaddr_wb),
        .regdata_wb    (regdata_wb),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_be         (dm_be),
        .dm_wdata      (dm_wdata),
        .dm_rdata      (dm_rdata),
        .dm_ack        (dm_ack),
        .mem_busy      (mem_busy),
        .instr_wb      (instr_wb),
        .pc_wb         (pc_wb),
        .reg_waddr_wb  (reg_waddr_wb),
        .reg_wdata_wb  (reg_wdata_wb),
        .tnew_wb       (tnew_wb),
        .acc_err_wb    (acc_err_wb)
    );

    typedef struct {
        logic [WIDTH_INSTR-1:0] instr;
        logic [31:0]            pc;
        logic [31:0]            addr;
        logic [31:0]            rt;
        logic [4:0]             rt_idx;
        logic [4:0]             fwd_addr;
        logic [31:0]            fwd_data;
        logic [31:0]            rdata;
        logic [4:0]             waddr;
        logic [31:0]            wdata;
        logic [WIDTH_T-1:0]     tnew;
        int                     delay;
    } op_t;

    typedef struct {
        bit                 start;
        bit                 err;
        logic               we;
        logic [31:0]        addr;
        logic [3:0]         be;
        logic [31:0]        wdata;
        int                 busy;
        int                 lat;
        logic [4:0]         waddr;
        logic [31:0]        wbdata;
        logic [WIDTH_T-1:0] tnew;
    } exp_t;

    typedef struct {
        int          busy;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        req_after;
        logic        err;
        logic [4:0]  waddr;
        logic [31:0] wb_wdata;
    } obs_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected behaviour derived directly from the access rules.
    function automatic exp_t model(input op_t op);
        exp_t        e;
        int          off;
        logic [31:0] rt;
        logic [31:0] v;
        bit          is_ld, is_st, is_w, is_h;
        e      = '{default: '0};
        off    = int'(op.addr % 32'd4);
        is_ld  = op.instr inside {IC_LW, IC_LH, IC_LHU, IC_LB, IC_LBU};
        is_st  = op.instr inside {IC_SW, IC_SH, IC_SB};
        is_w   = op.instr inside {IC_LW, IC_SW};
        is_h   = op.instr inside {IC_LH, IC_LHU, IC_SH};
        rt     = (op.fwd_addr == op.rt_idx && op.fwd_addr != 5'd0) ? op.fwd_data : op.rt;
        e.err  = (is_ld || is_st) && ((is_w && off != 0) || (is_h && (off % 2) != 0) || op.addr >= DM_TOP);
        e.start = (is_ld || is_st) && !e.err;
        e.we   = is_st;
        e.addr = op.addr - 32'(off);
        v      = 32'h0;
        case (op.instr)
            IC_SB: begin e.be = 4'(1 << off); e.wdata = (rt & 32'hFF) * 32'h0101_0101; end
            IC_SH: begin e.be = (off >= 2) ? 4'b1100 : 4'b0011; e.wdata = (rt & 32'hFFFF) * 32'h0001_0001; end
            IC_SW: begin e.be = 4'b1111; e.wdata = rt; end
            IC_LW: v = op.rdata;
            IC_LB: begin
                v = (op.rdata >> (8 * off)) & 32'hFF;
                if (v >= 32'h80) v = v - 32'h100;
            end
            IC_LBU: v = (op.rdata >> (8 * off)) & 32'hFF;
            IC_LH: begin
                v = (op.rdata >> (16 * (off / 2))) & 32'hFFFF;
                if (v >= 32'h8000) v = v - 32'h1_0000;
            end
            IC_LHU: v = (op.rdata >> (16 * (off / 2))) & 32'hFFFF;
            default: ;
        endcase
        e.busy   = e.start ? op.delay + 2 : 0;
        e.lat    = e.start ? op.delay + 3 : 1;
        e.waddr  = e.err ? 5'd0 : op.waddr;
        e.wbdata = (is_ld && !e.err) ? v : op.wdata;
        e.tnew   = (op.tnew != 2'd0) ? op.tnew - 2'd1 : 2'd0;
        return e;
    endfunction

    function automatic op_t mk_op(input logic [WIDTH_INSTR-1:0] ic, input logic [31:0] addr,
                                  input logic [31:0] rt, input logic [31:0] rdata, input int delay);
        op_t op;
        op.instr    = ic;
        op.addr     = addr;
        op.rt       = rt;
        op.rdata    = rdata;
        op.delay    = delay;
        op.pc       = $urandom & 32'hFFFF_FFFC;
        op.rt_idx   = 5'($urandom_range(1, 31));
        op.fwd_addr = 5'd0;
        op.fwd_data = $urandom;
        op.waddr    = 5'($urandom_range(1, 31));
        op.wdata    = $urandom;
        op.tnew     = 2'($urandom_range(0, 3));
        return op;
    endfunction

    // Issues one instruction, plays the memory side with the requested ack
    // delay and scores bus, busy, latency and MEM/WB contents.
    task automatic run_op(input op_t op, output obs_t ob);
        exp_t e;
        int   start;
        int   waits;
        e  = model(op);
        ob = '{default: '0};
        instr_mem     = op.instr;
        pc_mem        = op.pc;
        alu_out_mem   = op.addr;
        mem_wdata_mem = op.rt;
        addr_rt_mem   = op.rt_idx;
        reg_waddr_mem = op.waddr;
        reg_wdata_mem = op.wdata;
        tnew_mem      = op.tnew;
        regaddr_wb    = op.fwd_addr;
        regdata_wb    = op.fwd_data;
        dm_ack        = 1'b0;
        start         = cyc;
        #1;
        n_cmp++;
        if (mem_busy !== e.start) begin
            n_bad++;
            $display("FAIL busy_first instr=%0d addr=%h: got %b want %b", op.instr, op.addr, mem_busy, e.start);
        end
        waits = 0;
        while (mem_busy && ob.busy < 40) begin
            if (dm_req) begin
                n_cmp++;
                if ({dm_we, dm_addr, dm_be} !== {e.we, e.addr, e.be} || (e.we && dm_wdata !== e.wdata)) begin
                    n_bad++;
                    $display("FAIL bus instr=%0d: we/addr/be/wdata got %b/%h/%b/%h want %b/%h/%b/%h",
                             op.instr, dm_we, dm_addr, dm_be, dm_wdata, e.we, e.addr, e.be, e.wdata);
                end
                ob.addr  = dm_addr;
                ob.be    = dm_be;
                ob.wdata = dm_wdata;
                dm_ack   = (waits == op.delay);
                dm_rdata = dm_ack ? op.rdata : $urandom;
                waits++;
            end
            ob.busy++;
            @(posedge clk); #1;
            dm_ack     = 1'b0;
            regaddr_wb = 5'd0;
            regdata_wb = $urandom;
        end
        if (ob.busy >= 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout instr=%0d: busy never released", op.instr);
        end
        n_cmp++;
        if (ob.busy != e.busy) begin
            n_bad++;
            $display("FAIL busy_cycles instr=%0d: got %0d want %0d", op.instr, ob.busy, e.busy);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({instr_wb, pc_wb, reg_waddr_wb, tnew_wb, acc_err_wb} !== {op.instr, op.pc, e.waddr, e.tnew, e.err}
            || (!e.err && reg_wdata_wb !== e.wbdata)) begin
            n_bad++;
            $display("FAIL wb instr=%0d: ins/pc/wa/wd/t/err got %0d/%h/%0d/%h/%0d/%b want %0d/%h/%0d/%h/%0d/%b",
                     op.instr, instr_wb, pc_wb, reg_waddr_wb, reg_wdata_wb, tnew_wb, acc_err_wb,
                     op.instr, op.pc, e.waddr, e.wbdata, e.tnew, e.err);
        end
        n_cmp++;
        if (cyc - start != e.lat) begin
            n_bad++;
            $display("FAIL latency instr=%0d: got %0d want %0d", op.instr, cyc - start, e.lat);
        end
        n_cmp++;
        if (dm_req !== 1'b0) begin
            n_bad++;
            $display("FAIL req_after instr=%0d: got %b want 0", op.instr, dm_req);
        end
        ob.req_after = dm_req;
        ob.err       = acc_err_wb;
        ob.waddr     = reg_waddr_wb;
        ob.wb_wdata  = reg_wdata_wb;
        instr_mem    = IC_NOP;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({dm_req, dm_we, dm_addr, dm_be, dm_wdata, mem_busy, instr_wb, pc_wb, reg_waddr_wb,
             reg_wdata_wb, tnew_wb, acc_err_wb} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: req=%b we=%b addr=%h be=%b busy=%b instr_wb=%0d pc_wb=%h wd=%h err=%b want all 0",
                     dm_req, dm_we, dm_addr, dm_be, mem_busy, instr_wb, pc_wb, reg_wdata_wb, acc_err_wb);
        end
        reset = 1'b0;
    endtask

    task automatic test_store_word();
        op_t  op;
        obs_t ob;
        op = mk_op(IC_SW, 32'h10, 32'hDEAD_BEEF, 32'h0, 1);
        run_op(op, ob);
        n_cmp++;
        if ({ob.be, ob.addr, ob.wdata} !== {4'b1111, 32'h10, 32'hDEAD_BEEF} || ob.busy != 3) begin
            n_bad++;
            $display("FAIL sw_basic: be/addr/wdata/busy got %b/%h/%h/%0d want 1111/00000010/deadbeef/3",
                     ob.be, ob.addr, ob.wdata, ob.busy);
        end
    endtask

    task automatic test_byte_loads();
        op_t  op;
        obs_t ob;
        op = mk_op(IC_LB, 32'h13, 32'h0, 32'h80FF_0000, 0);
        run_op(op, ob);
        n_cmp++;
        if (ob.wb_wdata !== 32'hFFFF_FF80) begin
            n_bad++;
            $display("FAIL lb_sign: got %h want ffffff80", ob.wb_wdata);
        end
        op = mk_op(IC_LBU, 32'h13, 32'h0, 32'h80FF_0000, 2);
        run_op(op, ob);
        n_cmp++;
        if (ob.wb_wdata !== 32'h0000_0080) begin
            n_bad++;
            $display("FAIL lbu_zero: got %h want 00000080", ob.wb_wdata);
        end
    endtask

    task automatic test_half();
        op_t  op;
        obs_t ob;
        op = mk_op(IC_SH, 32'h12, 32'h0000_1234, 32'h0, 0);
        run_op(op, ob);
        n_cmp++;
        if ({ob.be, ob.wdata} !== {4'b1100, 32'h1234_1234}) begin
            n_bad++;
            $display("FAIL sh_lane: be/wdata got %b/%h want 1100/12341234", ob.be, ob.wdata);
        end
        op = mk_op(IC_LHU, 32'h12, 32'h0, 32'hABCD_0000, 1);
        run_op(op, ob);
        n_cmp++;
        if (ob.wb_wdata !== 32'h0000_ABCD) begin
            n_bad++;
            $display("FAIL lhu_zero: got %h want 0000abcd", ob.wb_wdata);
        end
    endtask

    task automatic test_errors();
        op_t  op;
        obs_t ob;
        op = mk_op(IC_LW, 32'h02, 32'h0, 32'h0, 0);
        run_op(op, ob);
        n_cmp++;
        if (ob.busy != 0 || {ob.req_after, ob.err, ob.waddr} !== {1'b0, 1'b1, 5'd0}) begin
            n_bad++;
            $display("FAIL lw_misalign: busy/req/err/waddr got %0d/%b/%b/%0d want 0/0/1/0",
                     ob.busy, ob.req_after, ob.err, ob.waddr);
        end
        op = mk_op(IC_SW, 32'h3000, 32'h5555_AAAA, 32'h0, 0);
        run_op(op, ob);
        n_cmp++;
        if (ob.busy != 0 || {ob.req_after, ob.err, ob.waddr} !== {1'b0, 1'b1, 5'd0}) begin
            n_bad++;
            $display("FAIL sw_range: busy/req/err/waddr got %0d/%b/%b/%0d want 0/0/1/0",
                     ob.busy, ob.req_after, ob.err, ob.waddr);
        end
        op = mk_op(IC_SW, 32'h2FFC, 32'h0102_0304, 32'h0, 0);
        run_op(op, ob);
        n_cmp++;
        if (ob.busy != 2 || ob.err !== 1'b0) begin
            n_bad++;
            $display("FAIL sw_last_word: busy/err got %0d/%b want 2/0", ob.busy, ob.err);
        end
    endtask

    task automatic test_forwarding();
        op_t  op;
        obs_t ob;
        op = mk_op(IC_SW, 32'h40, 32'h0000_1111, 32'h0, 2);
        op.rt_idx   = 5'd5;
        op.fwd_addr = 5'd5;
        op.fwd_data = 32'd7;
        run_op(op, ob);
        n_cmp++;
        if (ob.wdata !== 32'd7) begin
            n_bad++;
            $display("FAIL fwd_store: got %h want 00000007", ob.wdata);
        end
        op = mk_op(IC_SW, 32'h44, 32'h0000_2222, 32'h0, 0);
        op.rt_idx   = 5'd0;
        op.fwd_addr = 5'd0;
        op.fwd_data = 32'd7;
        run_op(op, ob);
        n_cmp++;
        if (ob.wdata !== 32'h0000_2222) begin
            n_bad++;
            $display("FAIL fwd_zero_reg: got %h want 00002222", ob.wdata);
        end
    endtask

    task automatic test_reset_mid_wait();
        op_t  op;
        obs_t ob;
        instr_mem   = IC_LW;
        alu_out_mem = 32'h20;
        dm_ack      = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (dm_req !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_wait_entry: dm_req got %b want 1", dm_req);
        end
        reset     = 1'b1;
        instr_mem = IC_NOP;
        @(posedge clk); #1;
        n_cmp++;
        if ({dm_req, mem_busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_wait_drop: req/busy got %b/%b want 0/0", dm_req, mem_busy);
        end
        reset    = 1'b0;
        dm_ack   = 1'b1;
        dm_rdata = $urandom;
        @(posedge clk); #1;
        dm_ack = 1'b0;
        n_cmp++;
        if ({dm_req, mem_busy, acc_err_wb} !== 3'b000) begin
            n_bad++;
            $display("FAIL late_ack: req/busy/err got %b/%b/%b want 0/0/0", dm_req, mem_busy, acc_err_wb);
        end
        op = mk_op(IC_ADDU, $urandom, 32'h0, 32'h0, 0);
        run_op(op, ob);
        n_cmp++;
        if (ob.busy != 0 || ob.wb_wdata !== op.wdata) begin
            n_bad++;
            $display("FAIL addu_after_rst: busy/wdata got %0d/%h want 0/%h", ob.busy, ob.wb_wdata, op.wdata);
        end
        op = mk_op(IC_LW, 32'h20, 32'h0, 32'hCAFE_F00D, 0);
        run_op(op, ob);
    endtask

    task automatic test_clear();
        instr_mem     = IC_ADDU;
        pc_mem        = 32'h0000_1000;
        reg_waddr_mem = 5'd9;
        reg_wdata_mem = 32'h1357_9BDF;
        tnew_mem      = 2'd2;
        clr           = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        n_cmp++;
        if ({instr_wb, pc_wb, reg_waddr_wb, reg_wdata_wb, tnew_wb, acc_err_wb} !== '0) begin
            n_bad++;
            $display("FAIL clr_flush: instr/pc/wa/wd got %0d/%h/%0d/%h want all 0",
                     instr_wb, pc_wb, reg_waddr_wb, reg_wdata_wb);
        end
        instr_mem = IC_NOP;
    endtask

    task automatic test_back_to_back();
        op_t  op1, op2;
        obs_t ob;
        int   start;
        logic [31:0] a;
        a     = ($urandom_range(0, 32'h2FFF)) & 32'hFFFF_FFFC;
        op1   = mk_op(IC_SW, a, $urandom, 32'h0, $urandom_range(0, 2));
        op2   = mk_op(IC_LW, a, 32'h0, $urandom, $urandom_range(0, 2));
        start = cyc;
        run_op(op1, ob);
        run_op(op2, ob);
        n_cmp++;
        if (cyc - start != op1.delay + op2.delay + 6) begin
            n_bad++;
            $display("FAIL back_to_back: cycles got %0d want %0d", cyc - start, op1.delay + op2.delay + 6);
        end
    endtask

    task automatic test_random();
        op_t  op;
        obs_t ob;
        logic [WIDTH_INSTR-1:0] ics [10];
        logic [31:0] a;
        int   sel;
        ics = '{IC_ADDU, IC_ORI, IC_LW, IC_LH, IC_LHU, IC_LB, IC_LBU, IC_SW, IC_SH, IC_SB};
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = DM_TOP + ($urandom & 32'h0000_FFFC);
            else if (sel == 1) a = $urandom;
            else               a = $urandom_range(0, 32'h2FFF);
            op = mk_op(ics[$urandom_range(0, 9)], a, $urandom, $urandom, $urandom_range(0, 3));
            if (sel > 3 && op.instr inside {IC_LW, IC_SW})          op.addr = op.addr & 32'hFFFF_FFFC;
            if (sel > 3 && op.instr inside {IC_LH, IC_LHU, IC_SH}) op.addr = op.addr & 32'hFFFF_FFFE;
            op.rt_idx = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 2))
                0:       op.fwd_addr = op.rt_idx;
                1:       op.fwd_addr = 5'd0;
                default: op.fwd_addr = 5'($urandom_range(0, 31));
            endcase
            run_op(op, ob);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        clr           = 1'b0;
        instr_mem     = IC_NOP;
        pc_mem        = '0;
        alu_out_mem   = '0;
        mem_wdata_mem = '0;
        addr_rt_mem   = '0;
        reg_waddr_mem = '0;
        reg_wdata_mem = '0;
        tnew_mem      = '0;
        regaddr_wb    = '0;
        regdata_wb    = '0;
        dm_rdata      = '0;
        dm_ack        = 1'b0;
        test_reset();
        test_store_word();
        test_byte_loads();
        test_half();
        test_errors();
        test_forwarding();
        test_reset_mid_wait();
        test_clear();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
